fusion_mac_seq: RTL

- Sequencer/accumulator wrapped around one internally instantiated fusion_unit.
- Accepts a job: precision config (cfga/cfgb), signedness, and a length N. Streams N operand pairs through the fusion unit with valid/ready, one pair per cycle, and accumulates per-lane partial sums.
- Presents the lane accumulators with a valid/ready result handshake.
- Sits between the operand buffers and the PE output/psum path of a bit-fusion PE.

---
 rtl/fusion_mac_seq.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fusion_mac_seq.sv
// Bit-fusion PE sequencer: streams packed operand pairs through a fusion_unit and
// accumulates up to four lane sums. Optional lane saturation with FUSION_MAC_SAT_EN.

module fusion_unit (
  input  logic [1:0]  i_cfga,
  input  logic [1:0]  i_cfgb,
  input  logic        i_sa,
  input  logic        i_sb,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [63:0] o_out,
  output logic [2:0]  o_lanes
);

  // Picks one 8/4/2-bit element of a packed operand and extends it to 16 bits.
  function automatic logic signed [15:0] elem(input logic [7:0] v, input logic [1:0] cfg,
                                              input logic s, input logic [1:0] idx);
    logic [3:0] nib;
    logic [1:0] crumb;
    logic signed [15:0] r;
    nib   = idx[0] ? v[7:4] : v[3:0];
    crumb = v[{idx, 1'b0} +: 2];
    case (cfg)
      2'b10:   r = s ? {{8{v[7]}}, v} : {8'b0, v};
      2'b01:   r = s ? {{12{nib[3]}}, nib} : {12'b0, nib};
      2'b00:   r = s ? {{14{crumb[1]}}, crumb} : {14'b0, crumb};
      default: r = 16'sd0;
    endcase
    return r;
  endfunction

  // Active lane count for the precision pair.
  always_comb begin
    case ({i_cfga, i_cfgb})
      4'b1010:          o_lanes = 3'd1;
      4'b1001, 4'b0110: o_lanes = 3'd2;
      default:          o_lanes = 3'd4;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_field
    localparam logic [1:0] F = 2'(g);
    logic [1:0]         w_ia;
    logic [1:0]         w_ib;
    logic signed [15:0] w_ea;
    logic signed [15:0] w_eb;
    logic signed [15:0] w_prod;
    logic               w_active;

    // 2-lane modes place their second product in field 2 (out[47:32]).
    always_comb begin
      w_ia     = (i_cfga == 2'b01) ? {1'b0, F[1]} : F;
      w_ib     = (i_cfgb == 2'b01) ? {1'b0, ((i_cfga == 2'b10) ? F[1] : F[0])} : F;
      w_ea     = elem(i_a, i_cfga, i_sa, w_ia);
      w_eb     = elem(i_b, i_cfgb, i_sb, w_ib);
      w_prod   = w_ea * w_eb;
      w_active = (o_lanes == 3'd4) || (F == 2'd0) || ((o_lanes == 3'd2) && (F == 2'd2));
    end

    assign o_out[16*g +: 16] = w_active ? w_prod : 16'd0;
  end

endmodule

module fusion_mac_seq #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         cfga,
  input  logic [1:0]         cfgb,
  input  logic               sa,
  input  logic               sb,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] acc,
  output logic [2:0]         lanes,
  output logic               busy,
  output logic               cfg_err
`ifdef FUSION_MAC_SAT_EN
  ,
  output logic               sat
`endif
);

`ifdef FUSION_MAC_SAT_EN
  localparam int RW = ACC_W + 1;
`else
  localparam int RW = ACC_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_cfga;
  logic [1:0]         r_cfgb;
  logic               r_sa;
  logic               r_sb;
  logic               r_sgn;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_count;
  logic [63:0]        r_prod;
  logic               r_pv;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_cfg_err;
  logic [4*ACC_W-1:0] r_acc;
  logic [2:0]         r_lanes;
`ifdef FUSION_MAC_SAT_EN
  logic               r_sat;
  logic [3:0]         w_clamp;
`endif

  logic [63:0]        w_prod;
  logic [2:0]         w_lanes;
  logic [15:0]        w_field [4];
  logic [3:0]         w_lane_on;
  logic [RW-1:0]      w_sum;
  logic [4*ACC_W-1:0] w_acc_next;
  logic [LEN_W-1:0]   w_count_inc;
  logic               w_cfg_bad;

  // Extends a 16-bit field and adds it to one lane; in the saturating build the MSB flags a clamp.
  function automatic logic [RW-1:0] lane_add(input logic [ACC_W-1:0] acc_v,
                                             input logic [15:0] fld, input logic sgn_v);
    logic [ACC_W-1:0] ext;
    logic [RW-1:0]    res;
    ext        = {ACC_W{sgn_v & fld[15]}};
    ext[15:0]  = fld;
`ifdef FUSION_MAC_SAT_EN
    res = {1'b0, acc_v} + {1'b0, ext};
    if (sgn_v) begin
      if ((acc_v[ACC_W-1] == ext[ACC_W-1]) && (res[ACC_W-1] != acc_v[ACC_W-1])) begin
        res = {1'b1, acc_v[ACC_W-1], {(ACC_W-1){~acc_v[ACC_W-1]}}};
      end else begin
        res = {1'b0, res[ACC_W-1:0]};
      end
    end else if (res[ACC_W]) begin
      res = {1'b1, {ACC_W{1'b1}}};
    end else begin
      res = {1'b0, res[ACC_W-1:0]};
    end
`else
    res = acc_v + ext;
`endif
    return res;
  endfunction

  fusion_unit u_fusion (
    .i_cfga  (r_cfga),
    .i_cfgb  (r_cfgb),
    .i_sa    (r_sa),
    .i_sb    (r_sb),
    .i_a     (a),
    .i_b     (b),
    .o_out   (w_prod),
    .o_lanes (w_lanes)
  );

  assign w_count_inc = r_count + LEN_W'(1);
  assign w_cfg_bad   = (cfga == 2'b11) || (cfgb == 2'b11) || (len == {LEN_W{1'b0}});

  // Next accumulator value from the registered product; lane 1 reads field 2 in 2-lane mode.
  always_comb begin
    w_field[0] = r_prod[15:0];
    w_field[1] = (w_lanes == 3'd2) ? r_prod[47:32] : r_prod[31:16];
    w_field[2] = r_prod[47:32];
    w_field[3] = r_prod[63:48];
    case (w_lanes)
      3'd1:    w_lane_on = 4'b0001;
      3'd2:    w_lane_on = 4'b0011;
      default: w_lane_on = 4'b1111;
    endcase
    w_sum      = {RW{1'b0}};
    w_acc_next = r_acc;
`ifdef FUSION_MAC_SAT_EN
    w_clamp    = 4'b0000;
`endif
    for (int k = 0; k < 4; k++) begin
      if (w_lane_on[k]) begin
        w_sum = lane_add(r_acc[k*ACC_W +: ACC_W], w_field[k], r_sgn);
        w_acc_next[k*ACC_W +: ACC_W] = w_sum[ACC_W-1:0];
`ifdef FUSION_MAC_SAT_EN
        w_clamp[k] = w_sum[ACC_W];
`endif
      end else begin
        w_acc_next[k*ACC_W +: ACC_W] = r_acc[k*ACC_W +: ACC_W];
      end
    end
  end

  // Job FSM, product pipeline and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfga      <= 2'b00;
      r_cfgb      <= 2'b00;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_sgn       <= 1'b0;
      r_len       <= {LEN_W{1'b0}};
      r_count     <= {LEN_W{1'b0}};
      r_prod      <= 64'd0;
      r_pv        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_acc       <= {(4*ACC_W){1'b0}};
      r_lanes     <= 3'd0;
`ifdef FUSION_MAC_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_cfg_err <= 1'b0;
      if (r_pv) begin
        r_acc <= w_acc_next;
`ifdef FUSION_MAC_SAT_EN
        r_sat <= r_sat | (|w_clamp);
`endif
      end
      case (r_state)
        S_IDLE: begin
          if (start && w_cfg_bad) begin
            r_cfg_err <= 1'b1;
          end else if (start) begin
            r_cfga     <= cfga;
            r_cfgb     <= cfgb;
            r_sa       <= sa;
            r_sb       <= sb;
            r_sgn      <= sa | sb;
            r_len      <= len;
            r_count    <= {LEN_W{1'b0}};
            r_acc      <= {(4*ACC_W){1'b0}};
            r_lanes    <= 3'd0;
`ifdef FUSION_MAC_SAT_EN
            r_sat      <= 1'b0;
`endif
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid && r_in_ready) begin
            r_prod  <= w_prod;
            r_pv    <= 1'b1;
            r_count <= w_count_inc;
            if (w_count_inc == r_len) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end else begin
            r_pv <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_pv        <= 1'b0;
          r_lanes     <= w_lanes;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign lanes     = r_lanes;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;
`ifdef FUSION_MAC_SAT_EN
  assign sat       = r_sat;
`endif

endmodule
